magnitude_sum_pipe: RTL and testbench
=====================================

Name: magnitude_sum_pipe

Overview:
- Parametrised, 3-stage pipelined same-sign floating-point magnitude adder. Successor to the half-precision combinational magnitude-sum block.
- Takes two packed IEEE-754-style operands and performs unpack, exponent compare/swap, alignment with guard/round/sticky, add, normalise, round-to-nearest-even, and pack internally.
- Sits behind the add/sub dispatcher, which routes only same-sign pairs here. Uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 5, exponent field width (5 = half, 8 = single).
- MAN_W, 10, stored fraction width (10 = half, 23 = single); word width W = 1+EXP_W+MAN_W.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  synchronous active-low reset.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  block accepts the pair this cycle.
- A  in  W  operand A, packed {sign, exp, frac}.
- B  in  W  operand B, packed.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- Q  out  W  packed result.
- FLAGS  out  5  [4]=SIGN_MISMATCH, [3]=SPECIAL (NaN/Inf input), [2]=TINY (result subnormal or zero), [1]=OF, [0]=INEXACT.

Behaviour:
- Reset: single clock, synchronous active-low reset, sampled on the CLK rising edge when RESET_N=0.
  - Stage valid bits, OUT_VALID, Q and FLAGS clear to 0.
  - Reset mid-operation discards all in-flight pairs; no partial result emerges.
- Handshake (global stall):
  - adv = !OUT_VALID | OUT_READY; IN_READY = adv (combinational).
  - A pair is accepted when IN_VALID & IN_READY. When adv=1 all stages shift one step; when adv=0 every stage register holds.
  - Bubbles are not collapsed.
  - Q/FLAGS stay stable while OUT_VALID=1 and OUT_READY=0.
  - Latency is 3 cycles from acceptance to OUT_VALID with no stall. Throughput is 1 pair/cycle. Results leave in acceptance order.
- Stage 1 (unpack/compare):
  - Hidden bit = (exp!=0). A subnormal uses effective exponent 1.
  - Swap so the operand with the larger effective exponent (ties: larger fraction) is L; the other is S. d = eL-eS.
  - Detect NaN (exp all ones, frac!=0), Inf (exp all ones, frac=0), and sign mismatch.
- Stage 2 (align/add):
  - Extend S mantissa with 3 bits G,R,St. Shift it right by d; bits shifted past St are OR-ed into St.
  - If d >= MAN_W+3, the aligned S becomes {0..0, St = (S mantissa != 0)}.
  - Sum = L mant + aligned S, width MAN_W+5 (1 carry bit).
- Stage 3 (normalise/round/pack):
  - Carry out: shift right 1 (LSB ORs into St), exponent +1.
  - Subnormal+subnormal sums that reach the hidden bit become normal with exponent 1; no left shift is ever needed.
  - RNE: round up iff G & (R | St | LSB). A mantissa overflow after rounding renormalises, exponent +1.
  - INEXACT = G|R|St before rounding.
  - Exponent reaching all ones gives Inf (frac=0) with OF=1 and INEXACT=1.
  - TINY=1 iff the final exponent field = 0.
  - Q sign = sign of A.
- Specials, decided in stage 1 and carried to stage 3; they override the arithmetic result:
  - Any NaN: Q = {0, all ones, 1, 0..0} (canonical qNaN), FLAGS = 5'b01000.
  - Inf + finite or Inf + Inf (same sign): Q = signed Inf, FLAGS = 5'b01000.
  - Sign mismatch (checked first, before NaN/Inf): Q = {sign A, 0..0}, FLAGS = 5'b10000.
- Zero + zero gives Q = signed zero, TINY=1.
- No state survives between pairs except the pipeline registers.

Test Plan:
- Half, no stall: A=0x3C00, B=0x3C00 -> Q=0x4000, FLAGS=0, OUT_VALID exactly 3 cycles after accept. Then A=0x3C00, B=0x1000 (tie) -> 0x3C00, FLAGS=00001. Then A=0x3C00, B=0x1001 -> 0x3C01, FLAGS=00001.
- Overflow/boundaries: 0x7BFF+0x7BFF -> 0x7C00, FLAGS=00011. 0x0001+0x0001 -> 0x0002, FLAGS=00100. 0x03FF+0x0001 -> 0x0400, FLAGS=0. 0x0000+0x0000 -> 0x0000, FLAGS=00100.
- Specials: 0x7E01+0x3C00 -> 0x7E00, FLAGS=01000. 0x7C00+0x3C00 -> 0x7C00, FLAGS=01000. 0x3C00+0xBC00 -> 0x0000, FLAGS=10000.
- Backpressure: stream 5 pairs back-to-back with OUT_READY=0 for cycles 4-8 -> IN_READY=0 while OUT_VALID=1 & OUT_READY=0. Q held stable; all 5 results delivered in order, none dropped or duplicated.
- Reset mid-flight: accept 2 pairs, pull RESET_N low for 1 cycle -> OUT_VALID=0, Q=0, FLAGS=0 next cycle; neither pair ever appears.
- EXP_W=8, MAN_W=23: 0x3F800000+0x33800000 (2^-24, tie) -> 0x3F800000, INEXACT. 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, FLAGS=00011.

Source files
------------

// File: rtl/magnitude_sum_pipe.sv
// rtl/magnitude_sum_pipe.sv - 3-stage pipelined same-sign floating-point magnitude adder
module magnitude_sum_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] Q,
  output logic [4:0]   FLAGS
);

  localparam int MW = MAN_W + 1;  // mantissa with hidden bit
  localparam int XW = MAN_W + 4;  // mantissa plus guard/round/sticky
  localparam int SW = MAN_W + 5;  // sum with carry bit

  typedef enum logic [1:0] {SP_NONE, SP_MISMATCH, SP_NAN, SP_INF} special_t;

  logic adv;
  assign adv      = !OUT_VALID || OUT_READY;
  assign IN_READY = adv;

  // ---------------- stage 1: unpack / compare / swap ----------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp, a_eff, b_eff;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [MW-1:0]    a_man, b_man;
  logic             a_nan, b_nan, a_inf, b_inf, a_is_l;
  special_t         c1_sp;

  always_comb begin
    a_sign = A[W-1];
    b_sign = B[W-1];
    a_exp  = A[W-2:MAN_W];
    b_exp  = B[W-2:MAN_W];
    a_frac = A[MAN_W-1:0];
    b_frac = B[MAN_W-1:0];
    a_eff  = (a_exp == '0) ? EXP_W'(1) : a_exp;
    b_eff  = (b_exp == '0) ? EXP_W'(1) : b_exp;
    a_man  = {a_exp != '0, a_frac};
    b_man  = {b_exp != '0, b_frac};
    a_nan  = (&a_exp) && (|a_frac);
    b_nan  = (&b_exp) && (|b_frac);
    a_inf  = (&a_exp) && !(|a_frac);
    b_inf  = (&b_exp) && !(|b_frac);
    a_is_l = {a_eff, a_man} >= {b_eff, b_man};
    if (a_sign != b_sign)     c1_sp = SP_MISMATCH;
    else if (a_nan || b_nan)  c1_sp = SP_NAN;
    else if (a_inf || b_inf)  c1_sp = SP_INF;
    else                      c1_sp = SP_NONE;
  end

  logic             s1_valid, s1_sign;
  special_t         s1_sp;
  logic [EXP_W-1:0] s1_e, s1_d;
  logic [MW-1:0]    s1_lm, s1_sm;

  // ---------------- stage 2: align with sticky, add ----------------
  logic [XW-1:0] s_ext, s_mask, s_shift, s_align;
  logic [SW-1:0] c2_sum;

  always_comb begin
    s_ext   = {s1_sm, 3'b000};
    s_mask  = '0;
    s_shift = '0;
    if (int'(s1_d) >= MAN_W + 3) begin
      s_align = {{(XW-1){1'b0}}, |s1_sm};
    end else begin
      s_mask  = ~({XW{1'b1}} << s1_d);
      s_shift = s_ext >> s1_d;
      s_align = s_shift | {{(XW-1){1'b0}}, |(s_ext & s_mask)};
    end
    c2_sum = {1'b0, s1_lm, 3'b000} + {1'b0, s_align};
  end

  logic             s2_valid, s2_sign;
  special_t         s2_sp;
  logic [EXP_W-1:0] s2_e;
  logic [SW-1:0]    s2_sum;

  // ---------------- stage 3: normalise / round / pack ----------------
  logic [XW-1:0]    n_m;
  logic [EXP_W:0]   n_e, f_e;
  logic [MAN_W+1:0] r_m;
  logic [MW-1:0]    f_man;
  logic             rnd_up, inexact, of;
  logic [W-1:0]     c3_q;
  logic [4:0]       c3_flags;

  always_comb begin
    if (s2_sum[SW-1]) begin
      n_m = s2_sum[SW-1:1] | {{(XW-1){1'b0}}, s2_sum[0]};
      n_e = {1'b0, s2_e} + (EXP_W+1)'(1);
    end else begin
      n_m = s2_sum[XW-1:0];
      n_e = {1'b0, s2_e};
    end
    inexact = |n_m[2:0];
    rnd_up  = n_m[2] && (n_m[1] || n_m[0] || n_m[3]);
    r_m     = {1'b0, n_m[XW-1:3]} + (MAN_W+2)'(rnd_up);
    if (r_m[MAN_W+1]) begin
      f_man = r_m[MAN_W+1:1];
      f_e   = n_e + (EXP_W+1)'(1);
    end else begin
      f_man = r_m[MW-1:0];
      f_e   = n_e;
    end
    // A clear hidden bit means the result stayed subnormal (or zero).
    of = f_man[MAN_W] && (f_e >= {1'b0, {EXP_W{1'b1}}});

    if (of) begin
      c3_q     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c3_flags = 5'b00011;
    end else if (!f_man[MAN_W]) begin
      c3_q     = {s2_sign, {EXP_W{1'b0}}, f_man[MAN_W-1:0]};
      c3_flags = {3'b001, 1'b0, inexact};
    end else begin
      c3_q     = {s2_sign, f_e[EXP_W-1:0], f_man[MAN_W-1:0]};
      c3_flags = {4'b0000, inexact};
    end

    case (s2_sp)
      SP_MISMATCH: begin
        c3_q     = {s2_sign, {(W-1){1'b0}}};
        c3_flags = 5'b10000;
      end
      SP_NAN: begin
        c3_q     = {1'b0, {EXP_W{1'b1}}, MAN_W'(1) << (MAN_W-1)};
        c3_flags = 5'b01000;
      end
      SP_INF: begin
        c3_q     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        c3_flags = 5'b01000;
      end
      default: ;
    endcase
  end

  // ---------------- pipeline registers (global stall) ----------------
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      OUT_VALID <= 1'b0;
      Q         <= '0;
      FLAGS     <= '0;
    end else if (adv) begin
      s1_valid  <= IN_VALID;
      s1_sign   <= a_sign;
      s1_sp     <= c1_sp;
      s1_e      <= a_is_l ? a_eff : b_eff;
      s1_d      <= a_is_l ? (a_eff - b_eff) : (b_eff - a_eff);
      s1_lm     <= a_is_l ? a_man : b_man;
      s1_sm     <= a_is_l ? b_man : a_man;

      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_sp     <= s1_sp;
      s2_e      <= s1_e;
      s2_sum    <= c2_sum;

      OUT_VALID <= s2_valid;
      Q         <= c3_q;
      FLAGS     <= c3_flags;
    end
  end

endmodule

// File: tb/tb_magnitude_sum_pipe.sv
// tb/tb_magnitude_sum_pipe.sv - scoreboard bench for magnitude_sum_pipe, half and single precision
module tb_magnitude_sum_pipe;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] q; logic [4:0] f; int acc; bit lat; } exp_h_t;
  typedef struct { logic [31:0] q; logic [4:0] f; } exp_s_t;

  exp_h_t sb_h[$];
  exp_s_t sb_s[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_q;
  logic [4:0]  h_flags;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_a, s_b, s_q;
  logic [4:0]  s_flags;

  magnitude_sum_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
    .CLK(clk), .RESET_N(resetn), .IN_VALID(h_in_valid), .IN_READY(h_in_ready),
    .A(h_a), .B(h_b), .OUT_VALID(h_out_valid), .OUT_READY(h_out_ready),
    .Q(h_q), .FLAGS(h_flags)
  );

  magnitude_sum_pipe #(.EXP_W(8), .MAN_W(23)) u_single (
    .CLK(clk), .RESET_N(resetn), .IN_VALID(s_in_valid), .IN_READY(s_in_ready),
    .A(s_a), .B(s_b), .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready),
    .Q(s_q), .FLAGS(s_flags)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Half-precision monitor: pops on every handshake, watches stall behaviour.
  logic [15:0] prev_q;
  logic [4:0]  prev_f;
  bit          prev_stall = 0;
  always @(negedge clk) begin
    exp_h_t e;
    if (!resetn) begin
      prev_stall = 0;
    end else begin
      if (h_out_valid && !h_out_ready) begin
        check("in_ready_stall", 32'(h_in_ready), 32'd0);
        if (prev_stall) begin
          check("q_hold", 32'(h_q), 32'(prev_q));
          check("flags_hold", 32'(h_flags), 32'(prev_f));
        end
        prev_stall = 1;
        prev_q = h_q;
        prev_f = h_flags;
      end else begin
        prev_stall = 0;
      end
      if (h_out_valid && h_out_ready) begin
        if (sb_h.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output_h: got q=%h, required no output", h_q);
        end else begin
          e = sb_h.pop_front();
          check("q_h", 32'(h_q), 32'(e.q));
          check("flags_h", 32'(h_flags), 32'(e.f));
          if (e.lat) check("latency_h", 32'(cyc - e.acc), 32'd3);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_s_t e;
    if (resetn && s_out_valid && s_out_ready) begin
      if (sb_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output_s: got q=%h, required no output", s_q);
      end else begin
        e = sb_s.pop_front();
        check("q_s", s_q, e.q);
        check("flags_s", 32'(s_flags), 32'(e.f));
      end
    end
  end

  task automatic send_h(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic [4:0] f, input bit lat);
    bit done = 0;
    h_in_valid = 1'b1;
    h_a = a;
    h_b = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (h_in_ready) begin
        sb_h.push_back('{q, f, cyc, lat});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_h: got no IN_READY, required accept of %h+%h", a, b);
    end
  endtask

  task automatic send_s(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [4:0] f);
    bit done = 0;
    s_in_valid = 1'b1;
    s_a = a;
    s_b = b;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (s_in_ready) begin
        sb_s.push_back('{q, f});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_s: got no IN_READY, required accept of %h+%h", a, b);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb_h.size() != 0 || sb_s.size() != 0); i++) @(posedge clk);
    #1;
    check("drain_h", 32'(sb_h.size()), 32'd0);
    check("drain_s", 32'(sb_s.size()), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_a = '0; h_b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(h_out_valid), 32'd0);
    check("rst_q", 32'(h_q), 32'd0);
    check("rst_flags", 32'(h_flags), 32'd0);
    check("rst_in_ready", 32'(h_in_ready), 32'd1);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back directed vectors, no stall: latency checked on each.
    send_h(16'h3C00, 16'h3C00, 16'h4000, 5'b00000, 1);
    send_h(16'h3C00, 16'h1000, 16'h3C00, 5'b00001, 1);
    send_h(16'h3C00, 16'h1001, 16'h3C01, 5'b00001, 1);
    send_h(16'h7BFF, 16'h7BFF, 16'h7C00, 5'b00011, 1);
    send_h(16'h0001, 16'h0001, 16'h0002, 5'b00100, 1);
    send_h(16'h03FF, 16'h0001, 16'h0400, 5'b00000, 1);
    send_h(16'h0000, 16'h0000, 16'h0000, 5'b00100, 1);
    send_h(16'h7E01, 16'h3C00, 16'h7E00, 5'b01000, 1);
    send_h(16'h7C00, 16'h3C00, 16'h7C00, 5'b01000, 1);
    send_h(16'h3C00, 16'hBC00, 16'h0000, 5'b10000, 1);
    h_in_valid = 1'b0;
    drain();

    // Backpressure: consumer stalls for 5 cycles while 5 pairs stream in.
    fork
      begin
        send_h(16'h3C00, 16'h3C00, 16'h4000, 5'b00000, 0);
        send_h(16'h4000, 16'h4000, 16'h4400, 5'b00000, 0);
        send_h(16'h3C00, 16'h4000, 16'h4200, 5'b00000, 0);
        send_h(16'h0001, 16'h0002, 16'h0003, 5'b00100, 0);
        send_h(16'h3800, 16'h3800, 16'h3C00, 5'b00000, 0);
        h_in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        h_out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        h_out_ready = 1'b1;
      end
    join
    drain();

    // Single precision.
    send_s(32'h3F800000, 32'h33800000, 32'h3F800000, 5'b00001);
    send_s(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5'b00011);
    s_in_valid = 1'b0;
    drain();

    // Reset mid-flight: two accepted pairs must vanish.
    send_h(16'h3C00, 16'h3C00, 16'h4000, 5'b00000, 0);
    send_h(16'h4000, 16'h4000, 16'h4400, 5'b00000, 0);
    h_in_valid = 1'b0;
    resetn = 1'b0;
    sb_h.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("midrst_out_valid", 32'(h_out_valid), 32'd0);
    check("midrst_q", 32'(h_q), 32'd0);
    check("midrst_flags", 32'(h_flags), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_quiet", 32'(h_out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
